// File: rtl/alu_writeback.sv
// Writeback / architectural-state stage behind the ALU controller.
// Captures ALU results for a one-cycle delayed register-file commit,
// holds the NZCV flag register fed back to the ALU, and provides two
// bypassed combinational read ports for the next instruction's operands.
module alu_writeback #(
    parameter int NREGS = 16,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    input  logic [W-1:0]             ex_result,
    input  logic [3:0]               ex_nzcv,
    input  logic                     ex_s,
    input  logic                     ex_we,
    input  logic [$clog2(NREGS)-1:0] ex_rd,
    input  logic [$clog2(NREGS)-1:0] rs1_addr,
    input  logic [$clog2(NREGS)-1:0] rs2_addr,
    output logic [W-1:0]             src1,
    output logic [W-1:0]             src2,
    output logic [3:0]               iNZCV,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_rd,
    output logic [W-1:0]             wb_result,
    output logic [31:0]              retired
);

    localparam int AW = $clog2(NREGS);

    logic [W-1:0]  rf_q [NREGS];

    logic          wb_valid_q,  wb_valid_d;
    logic [AW-1:0] wb_rd_q,     wb_rd_d;
    logic [W-1:0]  wb_result_q, wb_result_d;
    logic [3:0]    nzcv_q,      nzcv_d;
    logic [31:0]   retired_q,   retired_d;

    // Next-state for the capture stage, flags and retire counter.
    // Flags move on the capture edge so the very next ALU op sees them.
    always_comb begin
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_result_d = wb_result_q;
        nzcv_d      = nzcv_q;
        retired_d   = retired_q;
        if (ex_valid) begin
            wb_valid_d  = ex_we;
            wb_rd_d     = ex_rd;
            wb_result_d = ex_result;
            retired_d   = retired_q + 32'd1;
            if (ex_s) begin
                nzcv_d = ex_nzcv;
            end
        end
    end

    // State update: reset wins over both capture and the pending commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_result_q <= '0;
            nzcv_q      <= 4'b0000;
            retired_q   <= 32'd0;
        end else begin
            if (wb_valid_q) begin
                rf_q[wb_rd_q] <= wb_result_q;
            end
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_result_q <= wb_result_d;
            nzcv_q      <= nzcv_d;
            retired_q   <= retired_d;
        end
    end

    // Read ports: the pending writeback shadows the stale regfile entry.
    always_comb begin
        src1 = rf_q[rs1_addr];
        src2 = rf_q[rs2_addr];
        if (wb_valid_q && (rs1_addr == wb_rd_q)) begin
            src1 = wb_result_q;
        end
        if (wb_valid_q && (rs2_addr == wb_rd_q)) begin
            src2 = wb_result_q;
        end
    end

    assign iNZCV     = nzcv_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_result = wb_result_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: reset, write/read, flags, WAW bypass,
// back-to-back commits, carry flags and retire counter wrap.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [3:0]  ex_nzcv;
    logic        ex_s;
    logic        ex_we;
    logic [3:0]  ex_rd;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  iNZCV;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_ret = 32'd0;

    alu_writeback #(.NREGS(16), .W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_valid  (ex_valid),
        .ex_result (ex_result),
        .ex_nzcv   (ex_nzcv),
        .ex_s      (ex_s),
        .ex_we     (ex_we),
        .ex_rd     (ex_rd),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .src1      (src1),
        .src2      (src2),
        .iNZCV     (iNZCV),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_result (wb_result),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic s,
                         input logic [3:0] rd, input logic [31:0] res,
                         input logic [3:0] nzcv);
        ex_valid  = v;
        ex_we     = we;
        ex_s      = s;
        ex_rd     = rd;
        ex_result = res;
        ex_nzcv   = nzcv;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        rs1_addr = 4'd0;
        rs2_addr = 4'd0;
        step();
        step();
        rst = 1'b0;
        // r9 commits, then r3 is left pending when reset hits
        drive(1'b1, 1'b1, 1'b1, 4'd9, 32'h0000_1234, 4'b1001);
        step();
        drive(1'b1, 1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF, 4'b0000);
        step();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 4'd4, 32'h5555_5555, 4'b1111);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        exp_ret = 32'd0;
        for (int r = 0; r < 16; r++) begin
            rs1_addr = r[3:0];
            rs2_addr = 4'(15 - r);
            #1;
            checks++;
            if (src1 !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg src1 r%0d got=%h exp=%h", r, src1, 32'd0);
            end
            checks++;
            if (src2 !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg src2 r%0d got=%h exp=%h", 15 - r, src2, 32'd0);
            end
        end
        checks++;
        if (iNZCV !== 4'b0000) begin
            errors++;
            $display("FAIL reset_nzcv got=%b exp=%b", iNZCV, 4'b0000);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL reset_retired got=%h exp=%h", retired, 32'd0);
        end
        checks++;
        if ({wb_valid, wb_rd, wb_result} !== 37'd0) begin
            errors++;
            $display("FAIL reset_wb got=%b/%h/%h exp=0/0/0", wb_valid, wb_rd, wb_result);
        end
        // an idle cycle after reset must not resurrect the discarded r3 write
        step();
        rs1_addr = 4'd3;
        #1;
        checks++;
        if (src1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_discard r3 got=%h exp=%h", src1, 32'd0);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 1'b0, 4'd5, 32'd19, 4'b1010);
        step();
        exp_ret++;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        rs1_addr = 4'd5;
        rs2_addr = 4'd5;
        #1;
        checks++;
        if (src1 !== 32'd19 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL wr_bypass got=%0d wbv=%b exp=19 wbv=1", src1, wb_valid);
        end
        checks++;
        if (iNZCV !== 4'b0000) begin
            errors++;
            $display("FAIL wr_nzcv got=%b exp=%b", iNZCV, 4'b0000);
        end
        checks++;
        if (retired !== exp_ret) begin
            errors++;
            $display("FAIL wr_retired got=%h exp=%h", retired, exp_ret);
        end
        step();
        checks++;
        if (src1 !== 32'd19 || src2 !== 32'd19 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_regfile got=%0d/%0d wbv=%b exp=19/19 wbv=0", src1, src2, wb_valid);
        end
        checks++;
        if (retired !== exp_ret) begin
            errors++;
            $display("FAIL wr_idle_retired got=%h exp=%h", retired, exp_ret);
        end
    endtask

    task automatic test_flags();
        drive(1'b1, 1'b0, 1'b1, 4'd2, 32'hAAAA_AAAA, 4'b0100);
        step();
        exp_ret++;
        drive(1'b1, 1'b0, 1'b0, 4'd2, 32'hBBBB_BBBB, 4'b1111);
        rs1_addr = 4'd2;
        #1;
        checks++;
        if (iNZCV !== 4'b0100) begin
            errors++;
            $display("FAIL cmp_nzcv got=%b exp=%b", iNZCV, 4'b0100);
        end
        checks++;
        if (src1 !== 32'd0 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL cmp_r2 got=%h wbv=%b exp=0 wbv=0", src1, wb_valid);
        end
        checks++;
        if (retired !== exp_ret) begin
            errors++;
            $display("FAIL cmp_retired got=%h exp=%h", retired, exp_ret);
        end
        step();
        exp_ret++;
        checks++;
        if (iNZCV !== 4'b0100) begin
            errors++;
            $display("FAIL nos_nzcv got=%b exp=%b", iNZCV, 4'b0100);
        end
        // set-flags without a valid instruction must not touch flags
        drive(1'b0, 1'b1, 1'b1, 4'd2, 32'hCCCC_CCCC, 4'b1011);
        step();
        checks++;
        if (iNZCV !== 4'b0100 || src1 !== 32'd0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL idle_s got=%b/%h/%h exp=0100/0/%h", iNZCV, src1, retired, exp_ret);
        end
    endtask

    task automatic test_waw();
        rs1_addr = 4'd7;
        rs2_addr = 4'd7;
        drive(1'b1, 1'b1, 1'b0, 4'd7, 32'hFFFF_FFFF, 4'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 4'd7, 32'h0000_0001, 4'd0);
        checks++;
        if (src1 !== 32'hFFFF_FFFF || src2 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL waw_first got=%h/%h exp=ffffffff", src1, src2);
        end
        step();
        exp_ret += 2;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        checks++;
        if (src1 !== 32'd1 || src2 !== 32'd1) begin
            errors++;
            $display("FAIL waw_second got=%h/%h exp=1", src1, src2);
        end
        step();
        step();
        checks++;
        if (src1 !== 32'd1 || src2 !== 32'd1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL waw_drain got=%h/%h wbv=%b exp=1/1 wbv=0", src1, src2, wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 1'b0, 4'd10, 32'h0A0A_0A0A, 4'd0);
        step();
        drive(1'b1, 1'b1, 1'b0, 4'd11, 32'h0B0B_0B0B, 4'd0);
        step();
        exp_ret += 2;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        rs1_addr = 4'd10;
        rs2_addr = 4'd11;
        #1;
        checks++;
        if (src1 !== 32'h0A0A_0A0A || src2 !== 32'h0B0B_0B0B || wb_rd !== 4'd11) begin
            errors++;
            $display("FAIL b2b got=%h/%h rd=%0d exp=0a0a0a0a/0b0b0b0b rd=11", src1, src2, wb_rd);
        end
        step();
        // wb_rd/wb_result hold after an idle capture
        checks++;
        if (src2 !== 32'h0B0B_0B0B || wb_rd !== 4'd11 || wb_result !== 32'h0B0B_0B0B) begin
            errors++;
            $display("FAIL b2b_hold got=%h rd=%0d res=%h exp=0b0b0b0b rd=11", src2, wb_rd, wb_result);
        end
    endtask

    task automatic test_carry_flags();
        drive(1'b1, 1'b1, 1'b1, 4'd1, 32'd0, 4'b0110);
        step();
        exp_ret++;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        checks++;
        if (iNZCV !== 4'b0110) begin
            errors++;
            $display("FAIL carry_nzcv got=%b exp=%b", iNZCV, 4'b0110);
        end
        checks++;
        if (retired !== exp_ret) begin
            errors++;
            $display("FAIL carry_retired got=%h exp=%h", retired, exp_ret);
        end
    endtask

    task automatic test_counter_wrap();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        checks++;
        if (retired !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload got=%h exp=ffffffff", retired);
        end
        step();
        checks++;
        if (retired !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_idle got=%h exp=ffffffff", retired);
        end
        drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL wrap_zero got=%h exp=0", retired);
        end
        step();
        step();
        checks++;
        if (retired !== 32'd0) begin
            errors++;
            $display("FAIL wrap_hold got=%h exp=0", retired);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_flags();
        test_waw();
        test_back_to_back();
        test_carry_flags();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
